// File: rtl/odelay_load_sequencer_pkg.sv
// Shared definitions for the odelay load sequencer.
//  - seq_state_e    : sequencer FSM encoding (IDLE, LOAD, SET, SETTLE)
//  - DELAY_W        : width of the shared delay bus {coarse, fine}
//  - COARSE_W/FINE_W: field widths inside a delay word
//  - FINE_MAX_DEFAULT: largest legal fine value of the delay cells
//  - clamp_delay()  : saturates the fine field, passes coarse through
package odelay_load_sequencer_pkg;

  localparam int COARSE_W         = 5;
  localparam int FINE_W           = 3;
  localparam int DELAY_W          = COARSE_W + FINE_W;
  localparam int FINE_MAX_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SET    = 2'd2,
    ST_SETTLE = 2'd3
  } seq_state_e;

  // The fine taps above fine_max do not exist in the delay cell, so the
  // value saturates instead of wrapping; the coarse part is untouched.
  function automatic logic [DELAY_W-1:0] clamp_delay(
    input logic [DELAY_W-1:0] d,
    input logic [FINE_W-1:0]  fine_max
  );
    if (d[FINE_W-1:0] > fine_max)
      return {d[DELAY_W-1:FINE_W], fine_max};
    else
      return d;
  endfunction

endpackage

// File: rtl/odelay_load_sequencer_if.sv
// Command channel between the calibration sequencer (master) and the
// odelay load sequencer (slave).
//  cmd_valid  : command present
//  cmd_ready  : command accepted when cmd_valid & cmd_ready
//  cmd_lane   : target lane (ignored for commit)
//  cmd_delay  : {coarse, fine} delay word (ignored for commit)
//  cmd_commit : 0 = load one lane, 1 = apply all pending loads
interface odelay_load_sequencer_if #(
  parameter int LANE_BITS = 4
);
  import odelay_load_sequencer_pkg::*;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [LANE_BITS-1:0] cmd_lane;
  logic [DELAY_W-1:0]   cmd_delay;
  logic                 cmd_commit;

  modport master (
    output cmd_valid, cmd_lane, cmd_delay, cmd_commit,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_lane, cmd_delay, cmd_commit,
    output cmd_ready
  );

endinterface

// File: rtl/odelay_load_sequencer_shadow.sv
// odelay_seq_shadow: per-lane shadow of the values loaded into the delay
// bank (pending) and of the values made active by the last apply
// (committed), with a combinational readback mux.
//  clk, rst      : clock, asynchronous active-high reset (arrays clear to 0)
//  ld_en         : a dly_ld strobe is being issued this cycle
//  ld_lane       : lane receiving that strobe
//  ld_value      : value on the shared delay bus
//  set_en        : dly_set strobe; pending copies into committed for all lanes
//  rd_lane       : readback select; out-of-range lanes read 0
//  rd_pending    : pending value of rd_lane
//  rd_committed  : committed value of rd_lane
module odelay_seq_shadow
  import odelay_load_sequencer_pkg::*;
#(
  parameter int NUM_LANES = 16,
  parameter int LANE_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ld_en,
  input  logic [LANE_BITS-1:0] ld_lane,
  input  logic [DELAY_W-1:0]   ld_value,
  input  logic                 set_en,
  input  logic [LANE_BITS-1:0] rd_lane,
  output logic [DELAY_W-1:0]   rd_pending,
  output logic [DELAY_W-1:0]   rd_committed
);

  // Per-lane contributions to the read mux; a lane drives zero unless it
  // is selected, so an out-of-range select naturally reads 0.
  logic [NUM_LANES-1:0][DELAY_W-1:0] pend_sel;
  logic [NUM_LANES-1:0][DELAY_W-1:0] comm_sel;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    logic [DELAY_W-1:0] pending_reg;
    logic [DELAY_W-1:0] committed_reg;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pending_reg   <= '0;
        committed_reg <= '0;
      end else begin
        if (ld_en && (ld_lane == LANE_BITS'(gi)))
          pending_reg <= ld_value;
        if (set_en)
          committed_reg <= pending_reg;
      end
    end

    assign pend_sel[gi] = (rd_lane == LANE_BITS'(gi)) ? pending_reg   : '0;
    assign comm_sel[gi] = (rd_lane == LANE_BITS'(gi)) ? committed_reg : '0;
  end

  always_comb begin
    rd_pending   = '0;
    rd_committed = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      rd_pending   = rd_pending   | pend_sel[i];
      rd_committed = rd_committed | comm_sel[i];
    end
  end

endmodule

// File: rtl/odelay_load_sequencer.sv
// odelay_load_sequencer: sequences delay loads into a bank of NUM_LANES
// delay lanes sharing one delay bus. A load command drives the clamped
// delay onto dly_out and pulses that lane's dly_ld; a commit pulses the
// common dly_set, waits SETTLE_CYCLES and pulses done.
//  clk, rst      : clock, asynchronous active-high reset
//  cmd           : command channel (slave modport)
//  err_clr       : clears the sticky error flags (a new error wins)
//  dly_out       : shared delay bus, holds its last value
//  dly_ld        : one-hot per-lane load strobe
//  dly_set       : common apply strobe
//  busy          : SET/SETTLE in progress
//  done          : one-cycle pulse at end of settle
//  err_lane      : sticky, lane index >= NUM_LANES received
//  err_fine      : sticky, fine value > FINE_MAX received
//  rd_lane       : shadow readback select
//  rd_pending    : last loaded, not yet applied value of rd_lane
//  rd_committed  : last applied value of rd_lane
// Build option: define ODELAY_SEQ_SHADOW_EN to build the per-lane shadow
// registers; otherwise rd_pending and rd_committed are tied to 0.
module odelay_load_sequencer
  import odelay_load_sequencer_pkg::*;
#(
  parameter int NUM_LANES     = 16,
  parameter int LANE_BITS     = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int FINE_MAX      = FINE_MAX_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  odelay_load_sequencer_if.slave  cmd,
  input  logic                    err_clr,
  output logic [DELAY_W-1:0]      dly_out,
  output logic [NUM_LANES-1:0]    dly_ld,
  output logic                    dly_set,
  output logic                    busy,
  output logic                    done,
  output logic                    err_lane,
  output logic                    err_fine,
  input  logic [LANE_BITS-1:0]    rd_lane,
  output logic [DELAY_W-1:0]      rd_pending,
  output logic [DELAY_W-1:0]      rd_committed
);

  seq_state_e           state_reg,    state_next;
  logic [LANE_BITS-1:0] lane_reg,     lane_next;
  logic [DELAY_W-1:0]   dly_out_reg,  dly_out_next;
  logic [7:0]           cnt_reg,      cnt_next;
  logic                 err_lane_reg, err_lane_next;
  logic                 err_fine_reg, err_fine_next;
  // Holds cmd_ready low while in reset and releases it on the first clock
  // after reset deasserts.
  logic                 ready_en_reg;

  logic accept;
  logic lane_oor;
  logic fine_over;

  assign cmd.cmd_ready = ready_en_reg && (state_reg == ST_IDLE);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign lane_oor      = 32'(cmd.cmd_lane) >= NUM_LANES;
  assign fine_over     = cmd.cmd_delay[FINE_W-1:0] > FINE_W'(FINE_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      lane_reg     <= '0;
      dly_out_reg  <= '0;
      cnt_reg      <= '0;
      err_lane_reg <= 1'b0;
      err_fine_reg <= 1'b0;
      ready_en_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      lane_reg     <= lane_next;
      dly_out_reg  <= dly_out_next;
      cnt_reg      <= cnt_next;
      err_lane_reg <= err_lane_next;
      err_fine_reg <= err_fine_next;
      ready_en_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next    = state_reg;
    lane_next     = lane_reg;
    dly_out_next  = dly_out_reg;
    cnt_next      = cnt_reg;
    // Clear first, then let a fresh error re-set the flag so it wins.
    err_lane_next = err_lane_reg && !err_clr;
    err_fine_next = err_fine_reg && !err_clr;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (cmd.cmd_commit) begin
            state_next = ST_SET;
          end else if (lane_oor) begin
            // Dropped: no strobe, stay in IDLE.
            err_lane_next = 1'b1;
          end else begin
            state_next   = ST_LOAD;
            lane_next    = cmd.cmd_lane;
            dly_out_next = clamp_delay(cmd.cmd_delay, FINE_W'(FINE_MAX));
            if (fine_over)
              err_fine_next = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        state_next = ST_IDLE;
      end
      ST_SET: begin
        state_next = ST_SETTLE;
        cnt_next   = 8'(SETTLE_CYCLES - 1);
      end
      ST_SETTLE: begin
        if (cnt_reg == 8'd0)
          state_next = ST_IDLE;
        else
          cnt_next = cnt_reg - 8'd1;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Strobes are decoded from registered state so they drop the instant
  // the asynchronous reset forces the FSM back to IDLE.
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_ld
    assign dly_ld[gi] = (state_reg == ST_LOAD) && (lane_reg == LANE_BITS'(gi));
  end

  assign dly_out  = dly_out_reg;
  assign dly_set  = (state_reg == ST_SET);
  assign busy     = (state_reg == ST_SET) || (state_reg == ST_SETTLE);
  assign done     = (state_reg == ST_SETTLE) && (cnt_reg == 8'd0);
  assign err_lane = err_lane_reg;
  assign err_fine = err_fine_reg;

`ifdef ODELAY_SEQ_SHADOW_EN
  odelay_seq_shadow #(
    .NUM_LANES (NUM_LANES),
    .LANE_BITS (LANE_BITS)
  ) u_shadow (
    .clk          (clk),
    .rst          (rst),
    .ld_en        (state_reg == ST_LOAD),
    .ld_lane      (lane_reg),
    .ld_value     (dly_out_reg),
    .set_en       (dly_set),
    .rd_lane      (rd_lane),
    .rd_pending   (rd_pending),
    .rd_committed (rd_committed)
  );
`else
  logic unused_rd_lane;
  assign unused_rd_lane = ^rd_lane;
  assign rd_pending     = '0;
  assign rd_committed   = '0;
`endif

endmodule
